// File: rtl/monolith_round_sequencer.sv
// monolith_round_sequencer
// Runs one Monolith permutation through a single shared, externally supplied
// round core. It runs a concrete-only pre-round and then up to NUM_ROUNDS full
// rounds. Before each round it fetches that round's constants from an external
// synchronous ROM. A watchdog bounds how long it waits for each core result.
module monolith_round_sequencer #(
    parameter int WORD_WIDTH   = 31,
    parameter int STATE_SIZE   = 16,
    parameter int BAR_OP_COUNT = 8,
    parameter int NUM_ROUNDS   = 6,
    parameter int TIMEOUT      = 64,
    parameter int RW           = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] in_state,
    input  logic [RW-1:0]                         in_rounds,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] out_state,
    output logic                                  out_error,
    output logic [RW-1:0]                         const_addr,
    input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] const_data,
    output logic                                  core_load,
    output logic                                  core_pre,
    output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] core_state,
    output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] core_const,
    input  logic                                  core_valid,
    input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] core_result,
    output logic                                  busy,
    output logic [RW-1:0]                         round_idx
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RUN, DONE} fsm_t;

    localparam int            WDW      = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] MAX_RNDS = RW'(NUM_ROUNDS);

    fsm_t                                  fsm_q, fsm_d;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_q;
    logic [RW-1:0]                         rnds_q;
    logic [RW-1:0]                         round_q;
    logic [WDW-1:0]                        wd_q;
    logic                                  err_q;
    logic                                  wd_expired;
    logic                                  last_round;

    // The last allowed RUN cycle is the TIMEOUT-th one after LOAD.
    assign wd_expired = (wd_q == WDW'(TIMEOUT - 1));
    assign last_round = (round_q == rnds_q);

    // State register. Reset puts the FSM back in IDLE, and any result in flight is lost.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then
        // samples its pre-edge value, whatever order the blocks are evaluated in.
        if (reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    // Next-state logic. The core result takes priority over the watchdog on the final RUN cycle.
    always_comb begin
        // NOTE: a default assignment before the case keeps every path assigned.
        // Without it, synthesis infers a latch on fsm_d.
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid) fsm_d = FETCH;
            FETCH:   fsm_d = LOAD;
            LOAD:    fsm_d = RUN;
            RUN: begin
                if (core_valid)      fsm_d = last_round ? DONE : FETCH;
                else if (wd_expired) fsm_d = DONE;
            end
            DONE:    if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Datapath registers: the permutation state, the round counters, the watchdog and the error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            // State is a handful of flops rather than a RAM, so it clears on reset
            // and out_state is always defined.
            state_q <= '0;
            rnds_q  <= '0;
            round_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_state;
                        rnds_q  <= (in_rounds > MAX_RNDS) ? MAX_RNDS : in_rounds;
                        round_q <= '0;
                    end
                end
                LOAD: wd_q <= '0;
                RUN: begin
                    if (core_valid) begin
                        state_q <= core_result;
                        if (!last_round) round_q <= round_q + RW'(1);
                    end else if (wd_expired) begin
                        err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                DONE: if (out_ready) err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Output decode. Outputs depend only on the FSM state and registers. in_ready is also held low during reset.
    always_comb begin
        in_ready   = (fsm_q == IDLE) && !reset;
        busy       = (fsm_q != IDLE);
        core_load  = (fsm_q == LOAD);
        core_pre   = (fsm_q == LOAD) && (round_q == '0);
        out_valid  = (fsm_q == DONE);
        out_error  = err_q;
        out_state  = state_q;
        core_state = state_q;
        core_const = const_data;
        round_idx  = round_q;
        // Full round r reads ROM word r-1. The pre-round reads word 0 and ignores the data.
        const_addr = (round_q == '0) ? '0 : round_q - RW'(1);
    end

endmodule

// File: tb/tb_monolith_round_sequencer.sv
// Bench for monolith_round_sequencer. A stub round core with fixed latency L
// and a synchronous constant ROM surround the design. Each issued run pushes
// its expected result into a scoreboard. A monitor pops and compares when the
// design presents out_valid.
module tb_monolith_round_sequencer;

    localparam int WW   = 31;
    localparam int SS   = 16;
    localparam int NR   = 6;
    localparam int TO   = 64;
    localparam int RW   = $clog2(NR + 1);
    localparam int L    = 5;

    typedef logic [SS-1:0][WW-1:0] vec_t;

    typedef struct {
        vec_t st;
        logic err;
        int   lat;
        int   acc;
    } sb_item_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    vec_t          in_state;
    logic [RW-1:0] in_rounds;
    logic          out_valid;
    logic          out_ready;
    vec_t          out_state;
    logic          out_error;
    logic [RW-1:0] const_addr;
    vec_t          const_data;
    logic          core_load;
    logic          core_pre;
    vec_t          core_state;
    vec_t          core_const;
    logic          core_valid;
    vec_t          core_result;
    logic          busy;
    logic [RW-1:0] round_idx;

    int       checks   = 0;
    int       failures = 0;
    int       cyc      = 0;
    sb_item_t sb_q[$];
    int       addr_log[$];
    int       pre_log[$];
    bit       stall_r2 = 0;

    vec_t stub_state, stub_const;
    logic stub_pre, stub_active;
    int   stub_cnt;

    monolith_round_sequencer #(
        .WORD_WIDTH(WW), .STATE_SIZE(SS), .BAR_OP_COUNT(8),
        .NUM_ROUNDS(NR), .TIMEOUT(TO), .RW(RW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_rounds(in_rounds),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_error(out_error),
        .const_addr(const_addr), .const_data(const_data),
        .core_load(core_load), .core_pre(core_pre), .core_state(core_state), .core_const(core_const),
        .core_valid(core_valid), .core_result(core_result),
        .busy(busy), .round_idx(round_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Constant ROM: every word at address a holds a+1, with a one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < SS; i++) const_data[i] <= WW'(const_addr) + WW'(1);
    end

    // Stub core: samples the operands on load. It raises core_valid in the L-th RUN cycle, unless this is the stalled round.
    always @(posedge clk) begin
        if (reset) begin
            stub_active <= 1'b0;
            stub_cnt    <= 0;
        end else if (core_load) begin
            stub_state  <= core_state;
            stub_const  <= core_const;
            stub_pre    <= core_pre;
            stub_cnt    <= 1;
            stub_active <= !(stall_r2 && round_idx == RW'(2));
            addr_log.push_back(int'(const_addr));
            pre_log.push_back(int'(core_pre));
        end else if (stub_active) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == L) stub_active <= 1'b0;
        end
    end

    assign core_valid = stub_active && (stub_cnt == L);

    // Stub round function: the state alone for the pre-round, otherwise state + constant per word.
    always_comb begin
        core_result = stub_state;
        if (!stub_pre)
            for (int i = 0; i < SS; i++) core_result[i] = stub_state[i] + stub_const[i];
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t fill(input int v);
        vec_t r;
        for (int i = 0; i < SS; i++) r[i] = WW'(v);
        return r;
    endfunction

    function automatic vec_t ramp(input int base, input int step);
        vec_t r;
        for (int i = 0; i < SS; i++) r[i] = WW'(base + step * i);
        return r;
    endfunction

    // Offers a state, waits (bounded) for acceptance and records the expected response.
    task automatic issue(input vec_t st, input int rnds, input vec_t exp, input logic err, input int lat);
        int n;
        sb_item_t it;
        @(negedge clk);
        in_state  = st;
        in_rounds = RW'(rnds);
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_seen", in_ready, 1'b1);
        if (in_ready) begin
            it.st = exp; it.err = err; it.lat = lat; it.acc = cyc + 1;
            sb_q.push_back(it);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("result_seen", out_valid, 1'b1);
    endtask

    task automatic wait_result(input int limit);
        wait_valid(limit);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Monitor: compares one scoreboard entry each time out_valid rises.
    initial begin
        bit seen;
        sb_item_t it;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1'b1, 1'b0);
                end else begin
                    it = sb_q.pop_front();
                    check("out_state", out_state, it.st);
                    check("out_error", out_error, it.err);
                    check("latency", cyc - it.acc, it.lat);
                end
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    initial begin
        int   base;
        int   exp_addr[7];
        vec_t snap;
        exp_addr  = '{0, 0, 1, 2, 3, 4, 5};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_rounds = '0;
        out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);
        check("reset_flags", {out_valid, out_error, busy, core_load, core_pre}, 5'b0);
        check("reset_round_idx", round_idx, 0);
        check("reset_const_addr", const_addr, 0);
        check("reset_out_state", out_state, 0);

        // Full six-round run: 1 + (1+2+...+6) = 22 in every word; 7 rounds of 7 cycles.
        base = addr_log.size();
        issue(fill(1), 6, fill(22), 1'b0, 49);
        wait_result(200);
        check("loads_six_rounds", addr_log.size() - base, 7);
        check("pre_first_round", pre_log[base], 1);
        check("pre_second_round", pre_log[base + 1], 0);

        // Pre-round only: one load with core_pre set, state passes through, 7 cycles.
        base = addr_log.size();
        issue(ramp(3, 7), 0, ramp(3, 7), 1'b0, 7);
        wait_result(50);
        check("loads_pre_only", addr_log.size() - base, 1);
        check("pre_only_core_pre", pre_log[base], 1);

        // Over-range rounds request clamps to NUM_ROUNDS: adds 21 and walks addresses 0,0,1..5.
        base = addr_log.size();
        issue(ramp(0, 1), 7, ramp(21, 1), 1'b0, 49);
        wait_result(200);
        check("loads_clamped", addr_log.size() - base, 7);
        for (int i = 0; i < 7; i++) check("const_addr_seq", addr_log[base + i], exp_addr[i]);

        // Core stalls in round 2: error reported after TIMEOUT RUN cycles, round-1 state kept.
        stall_r2 = 1'b1;
        issue(ramp(100, 1), 4, ramp(101, 1), 1'b1, 7 + 7 + 2 + TO);
        wait_valid(300);
        stall_r2 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("error_cleared", out_error, 1'b0);

        // Back-pressure in DONE with a competing in_valid, then handshake and immediate re-accept.
        issue(fill(5), 1, fill(6), 1'b0, 14);
        wait_valid(100);
        snap      = out_state;
        in_state  = fill(9);
        in_rounds = RW'(2);
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_state", out_state, snap);
            check("hold_flags", {out_valid, out_error, in_ready}, 3'b100);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("turnaround_in_ready", in_ready, 1'b1);
        check("turnaround_out_valid", out_valid, 1'b0);
        begin
            sb_item_t it;
            it.st = fill(12); it.err = 1'b0; it.lat = 21; it.acc = cyc + 1;
            sb_q.push_back(it);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(100);

        // Reset during RUN of round 3 drops the run; a following run completes normally.
        issue(fill(2), 5, fill(0), 1'b0, 0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(core_load && round_idx == RW'(3)) && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("round3_load_seen", core_load, 1'b1);
        end
        @(negedge clk);
        reset = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("abort_flags", {busy, out_valid, core_load, in_ready}, 4'b0);
        check("abort_round_idx", round_idx, 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        issue(ramp(1000, 1), 3, ramp(1006, 1), 1'b0, 28);
        wait_result(100);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
